// File: rtl/reg_writeback_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback_unit_pkg
// Brief    : Shared register-file types and constants (writeback, RF, hazards)
// Revision : 1.0
// ============================================================================
package reg_writeback_unit_pkg;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 32;
    localparam int REG_COUNT = 32;

    localparam logic [ADDR_W-1:0] X0 = '0;

    typedef struct packed {
        logic              kill;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage : reg_writeback_unit_pkg
`default_nettype wire

// File: rtl/reg_writeback_unit_late_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_late_fifo
// Brief    : Circular late-result buffer with kill-by-address and live-rd mask
// Revision : 1.0
// ============================================================================
module wb_late_fifo
    import reg_writeback_unit_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_i,
    input  logic [ADDR_W-1:0]    push_rd_i,
    input  logic [DATA_W-1:0]    push_data_i,
    input  logic                 pop_i,
    input  logic                 kill_en_i,
    input  logic [ADDR_W-1:0]    kill_rd_i,
    output logic                 head_kill_o,
    output logic [ADDR_W-1:0]    head_rd_o,
    output logic [DATA_W-1:0]    head_data_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [REG_COUNT-1:0] live_mask_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  valid_q, kill_q, hit;
    logic [ADDR_W-1:0] rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic              push_kill;

    // A same-cycle pipe write to the pushed rd makes the new entry stale on arrival.
    assign push_kill = kill_en_i && (push_rd_i == kill_rd_i);

    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_hit
        assign hit[gi] = kill_en_i && valid_q[gi] && (rd_q[gi] == kill_rd_i);
    end

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            kill_q   <= '0;
        end else begin
            count_q <= count_d;
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (push_i && (wr_ptr_q == PTR_W'(i))) begin
                    valid_q[i] <= 1'b1;
                    kill_q[i]  <= push_kill;
                end else if (pop_i && (rd_ptr_q == PTR_W'(i))) begin
                    valid_q[i] <= 1'b0;
                    kill_q[i]  <= 1'b0;
                end else if (hit[i]) begin
                    kill_q[i]  <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push_i && (wr_ptr_q == PTR_W'(i))) begin
                rd_q[i]   <= push_rd_i;
                data_q[i] <= push_data_i;
            end
        end
    end

    always_comb begin
        live_mask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !kill_q[i]) live_mask_o[rd_q[i]] = 1'b1;
        end
    end

    assign head_kill_o = kill_q[rd_ptr_q];
    assign head_rd_o   = rd_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);

endmodule : wb_late_fifo
`default_nettype wire

// File: rtl/reg_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback_unit
// Brief    : Merges pipeline and late writebacks into one registered RF write
// Revision : 1.0
// ============================================================================
module reg_writeback_unit
    import reg_writeback_unit_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_wen_i,
    input  logic [ADDR_W-1:0] pipe_rd_i,
    input  logic [DATA_W-1:0] pipe_data_i,
    input  logic              late_valid_i,
    output logic              late_ready_o,
    input  logic [ADDR_W-1:0] late_rd_i,
    input  logic [DATA_W-1:0] late_data_i,
    output logic [ADDR_W-1:0] RDaddr_o,
    output logic [DATA_W-1:0] RDdata_o,
    output logic              RegWrite_o,
    output logic [31:0]       pend_mask_o,
    output logic              stall_o,
    output logic              fifo_full_o,
    output logic              fifo_empty_o
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    logic              pipe_wr, push, pop;
    logic              fifo_full, fifo_empty, head_kill;
    logic [ADDR_W-1:0] head_rd;
    logic [DATA_W-1:0] head_data;

    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [STARVE_W-1:0] starve_q, starve_d;

    assign pipe_wr = pipe_wen_i && (pipe_rd_i != ADDR_W'(X0));
    assign push    = late_valid_i && !fifo_full && (late_rd_i != ADDR_W'(X0));
    assign pop     = !pipe_wr && !fifo_empty;

    wb_late_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_rd_i   (late_rd_i),
        .push_data_i (late_data_i),
        .pop_i       (pop),
        .kill_en_i   (pipe_wr),
        .kill_rd_i   (pipe_rd_i),
        .head_kill_o (head_kill),
        .head_rd_o   (head_rd),
        .head_data_o (head_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .live_mask_o (pend_mask_o)
    );

    // Address/data hold on idle and killed-pop cycles; only RegWrite drops.
    always_comb begin
        reg_write_d = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        if (pipe_wr) begin
            reg_write_d = 1'b1;
            rd_addr_d   = pipe_rd_i;
            rd_data_d   = pipe_data_i;
        end else if (pop && !head_kill) begin
            reg_write_d = 1'b1;
            rd_addr_d   = head_rd;
            rd_data_d   = head_data;
        end
    end

    always_comb begin
        if (fifo_empty || pop)
            starve_d = '0;
        else if (starve_q != STARVE_W'(STARVE_MAX))
            starve_d = starve_q + 1'b1;
        else
            starve_d = starve_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_q <= 1'b0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
            starve_q    <= '0;
        end else begin
            reg_write_q <= reg_write_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
            starve_q    <= starve_d;
        end
    end

    assign RegWrite_o   = reg_write_q;
    assign RDaddr_o     = rd_addr_q;
    assign RDdata_o     = rd_data_q;
    assign stall_o      = (starve_q == STARVE_W'(STARVE_MAX));
    assign fifo_full_o  = fifo_full;
    assign fifo_empty_o = fifo_empty;
    assign late_ready_o = !fifo_full;

endmodule : reg_writeback_unit
`default_nettype wire

// File: tb/tb_reg_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_writeback_unit
// Brief    : Directed self-checking bench for reg_writeback_unit
// Revision : 1.0
// ============================================================================
module tb_reg_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wen_i;
    logic [4:0]  pipe_rd_i;
    logic [31:0] pipe_data_i;
    logic        late_valid_i;
    logic        late_ready_o;
    logic [4:0]  late_rd_i;
    logic [31:0] late_data_i;
    logic [4:0]  RDaddr_o;
    logic [31:0] RDdata_o;
    logic        RegWrite_o;
    logic [31:0] pend_mask_o;
    logic        stall_o;
    logic        fifo_full_o;
    logic        fifo_empty_o;

    int checks = 0;
    int errors = 0;

    reg_writeback_unit #(
        .DEPTH      (4),
        .DATA_W     (32),
        .ADDR_W     (5),
        .STARVE_MAX (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_wen_i   (pipe_wen_i),
        .pipe_rd_i    (pipe_rd_i),
        .pipe_data_i  (pipe_data_i),
        .late_valid_i (late_valid_i),
        .late_ready_o (late_ready_o),
        .late_rd_i    (late_rd_i),
        .late_data_i  (late_data_i),
        .RDaddr_o     (RDaddr_o),
        .RDdata_o     (RDdata_o),
        .RegWrite_o   (RegWrite_o),
        .pend_mask_o  (pend_mask_o),
        .stall_o      (stall_o),
        .fifo_full_o  (fifo_full_o),
        .fifo_empty_o (fifo_empty_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then settle before sampling.
    task automatic step(input logic pw, input logic [4:0] prd, input logic [31:0] pd,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        pipe_wen_i   = pw;
        pipe_rd_i    = prd;
        pipe_data_i  = pd;
        late_valid_i = lv;
        late_rd_i    = lrd;
        late_data_i  = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        pipe_wen_i = 1'b0; pipe_rd_i = '0; pipe_data_i = '0;
        late_valid_i = 1'b0; late_rd_i = '0; late_data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_regwrite", RegWrite_o, 0);
        chk("rst_addr",     RDaddr_o,   0);
        chk("rst_data",     RDdata_o,   0);
        chk("rst_stall",    stall_o,    0);
        chk("rst_pend",     pend_mask_o, 0);
        chk("rst_empty",    fifo_empty_o, 1);
        chk("rst_full",     fifo_full_o,  0);
        chk("rst_ready",    late_ready_o, 1);
        rst = 1'b0;

        // Pipe-only writes
        step(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0);
        chk("pipe1_we",   RegWrite_o, 1);
        chk("pipe1_addr", RDaddr_o,   5);
        chk("pipe1_data", RDdata_o,   32'h11);
        step(1'b1, 5'd6, 32'h22, 1'b0, 5'd0, 32'h0);
        chk("pipe2_we",   RegWrite_o, 1);
        chk("pipe2_addr", RDaddr_o,   6);
        chk("pipe2_data", RDdata_o,   32'h22);
        chk("pipe2_empty", fifo_empty_o, 1);
        idle();
        chk("idle_we",   RegWrite_o, 0);
        chk("idle_hold", RDaddr_o,   6);

        // Late drain
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hAA);
        chk("late_pend",  pend_mask_o, 32'h80);
        chk("late_we0",   RegWrite_o, 0);
        chk("late_empty", fifo_empty_o, 0);
        idle();
        chk("late_we",    RegWrite_o, 1);
        chk("late_addr",  RDaddr_o,   7);
        chk("late_data",  RDdata_o,   32'hAA);
        chk("late_pend0", pend_mask_o, 0);

        // Squash
        step(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h1);
        chk("sq_we3",   RegWrite_o, 1);
        chk("sq_addr3", RDaddr_o,   3);
        chk("sq_pend9", pend_mask_o, 32'h200);
        step(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'h0);
        chk("sq_addr9", RDaddr_o,   9);
        chk("sq_data9", RDdata_o,   32'h2);
        chk("sq_pend0", pend_mask_o, 0);
        chk("sq_nempty", fifo_empty_o, 0);
        idle();
        chk("sq_killpop_we", RegWrite_o, 0);
        chk("sq_killpop_data", RDdata_o, 32'h2);
        chk("sq_empty",  fifo_empty_o, 1);

        // Fill while the pipe keeps every slot busy
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 5'd1, 32'(i), 1'b1, 5'(10 + i), 32'hA0 + 32'(i));
        end
        chk("full_full",  fifo_full_o, 1);
        chk("full_ready", late_ready_o, 0);
        chk("full_pend",  pend_mask_o, 32'h3C00);
        step(1'b1, 5'd1, 32'h4, 1'b1, 5'd14, 32'hEE);
        chk("full_held_pend", pend_mask_o, 32'h3C00);
        chk("full_held_full", fifo_full_o, 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'd1, 32'h5 + 32'(i), 1'b0, 5'd0, 32'h0);
        end
        chk("stall_pre", stall_o, 0);
        step(1'b1, 5'd1, 32'h8, 1'b0, 5'd0, 32'h0);
        chk("stall_on", stall_o, 1);
        idle();
        chk("drain_we",    RegWrite_o, 1);
        chk("drain_addr",  RDaddr_o,   10);
        chk("drain_data",  RDdata_o,   32'hA0);
        chk("drain_stall", stall_o, 0);
        chk("drain_ready", late_ready_o, 1);
        chk("drain_pend",  pend_mask_o, 32'h3800);

        // Async reset with three entries still queued
        #2 rst = 1'b1;
        #1;
        chk("arst_we",    RegWrite_o, 0);
        chk("arst_addr",  RDaddr_o,   0);
        chk("arst_data",  RDdata_o,   0);
        chk("arst_pend",  pend_mask_o, 0);
        chk("arst_empty", fifo_empty_o, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("arst_nowrite", RegWrite_o, 0);
        end
        chk("arst_ready", late_ready_o, 1);

        // x0 late push is dropped
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55);
        chk("x0_empty", fifo_empty_o, 1);
        chk("x0_pend",  pend_mask_o, 0);
        idle();
        chk("x0_we", RegWrite_o, 0);

        // Same-cycle push and pipe write to x4
        step(1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 32'h99);
        chk("sim_addr",  RDaddr_o, 4);
        chk("sim_data",  RDdata_o, 32'h44);
        chk("sim_pend",  pend_mask_o, 0);
        chk("sim_nempty", fifo_empty_o, 0);
        idle();
        chk("sim_killpop_we", RegWrite_o, 0);
        chk("sim_hold_data",  RDdata_o, 32'h44);
        chk("sim_empty", fifo_empty_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reg_writeback_unit
`default_nettype wire

// File: doc/reg_writeback_unit.md
Name: reg_writeback_unit

Overview:
- Writer side of the integer register-file write port: merges in-order pipeline writebacks and out-of-order late results (load/multiplier returns) into one registered RDaddr/RDdata/RegWrite stream.
- Late results are buffered in a small FIFO. Pipeline writes have priority. Superseded late results are squashed.
- Exports a pending-destination mask for hazard detection, and a stall request when the FIFO is starved of drain slots.

Parameters:
- DEPTH, 4, late-result FIFO entries (power of two, >=2)
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- STARVE_MAX, 8, consecutive cycles a non-empty FIFO may go without a drain slot before stall_o asserts

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- pipe_wen_i  in  1  pipeline writeback valid
- pipe_rd_i  in  ADDR_W  pipeline destination register
- pipe_data_i  in  DATA_W  pipeline writeback data
- late_valid_i  in  1  late result offered
- late_ready_o  out  1  late result accepted this cycle when valid&ready
- late_rd_i  in  ADDR_W  late result destination
- late_data_i  in  DATA_W  late result data
- RDaddr_o  out  ADDR_W  register-file write address (registered)
- RDdata_o  out  DATA_W  register-file write data (registered)
- RegWrite_o  out  1  register-file write enable (registered)
- pend_mask_o  out  32  bit r set = live late write to r pending in FIFO
- stall_o  out  1  request one pipeline bubble so the FIFO can drain
- fifo_full_o  out  1  FIFO holds DEPTH entries
- fifo_empty_o  out  1  FIFO holds 0 entries

Behaviour:
- Reset (async, rst=1): FIFO count, pointers, kill bits and starve counter = 0. RegWrite_o=0, RDaddr_o=0, RDdata_o=0, stall_o=0, pend_mask_o=0, fifo_empty_o=1, fifo_full_o=0, late_ready_o=1.
- Reset mid-operation discards all FIFO contents. No write is issued for discarded entries.
- late_ready_o = ~fifo_full_o. Ready is derived from registered count only, so a pop in the same cycle does not free a slot.
- Push: late_valid_i & late_ready_o. A push with late_rd_i==0 is accepted and dropped; it is never stored.
- Write selection per cycle (the chosen write appears on the outputs one cycle later):
  - pipe_wen_i & pipe_rd_i!=0: output the pipe write. No pop.
  - Else, FIFO non-empty: pop the head.
    - Live head: output its write.
    - Killed head: RegWrite_o=0 next cycle; the pop still consumes the entry.
  - Else: RegWrite_o=0, and RDaddr_o/RDdata_o hold their previous values.
- pipe_wen_i with pipe_rd_i==0 counts as no pipe write, and that cycle is a drain slot.
- Squash rule (pipeline is the newer producer): a pipe write to rd sets the kill bit of every stored entry with that rd. A same-cycle push to the same rd is stored already killed.
- pend_mask_o: OR over live stored entries of one-hot(rd). It depends only on registered state. Killed entries do not contribute.
- Simultaneous push and pop: both take effect. Count unchanged; head and tail advance.
- Pointers wrap modulo DEPTH.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and no pop occurs.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_MAX.
  - stall_o = (counter==STARVE_MAX), registered.
  - The upstream pipeline responds with pipe_wen_i=0. The next pop clears stall_o the following cycle.
- Only a pop changes the FIFO's count downward. The register file sees at most one write per cycle.

Decomposition:
- Shared package (used with the register file and hazard unit): ADDR_W, DATA_W, REG_COUNT=32, the wb_entry_t typedef {kill, rd, data}, and the X0 constant.
- One sub-module: wb_late_fifo.
  - Circular DEPTH-entry buffer with push/pop.
  - Kill-by-address input (kill_en, kill_rd).
  - Outputs: head entry, full/empty, per-entry live-rd mask.
- The top level holds the output registers, write selection and starve counter.

Test Plan:
- Pipe-only: pipe writes x5=0x11 then x6=0x22 on consecutive cycles -> RegWrite_o=1 one cycle later with (5,0x11) then (6,0x22); FIFO stays empty.
- Late drain: push late x7=0xAA with pipe idle -> pend_mask_o bit7=1 the next cycle; write (7,0xAA) appears two cycles after the push; mask bit7 clears after the pop.
- Squash: push late x9=0x1 while the pipe busily writes x3, then pipe writes x9=0x2 -> pend_mask_o bit9 drops; the register file receives only (9,0x2); the later pop of the killed entry gives a RegWrite_o=0 cycle.
- Full/backpressure: push 4 entries with the pipe writing continuously -> fifo_full_o=1, late_ready_o=0; a 5th valid is held off; after STARVE_MAX=8 starved cycles stall_o=1; one idle pipe cycle pops the entry and clears stall_o.
- x0 and simultaneity: late push to x0 -> no entry stored, fifo_empty_o stays 1. Push x4 and pipe-write x4 in the same cycle -> only the pipe write reaches RegWrite_o.
- Async reset with 3 entries queued: assert rst between clock edges -> outputs zero immediately; after release no stale writes occur and late_ready_o=1.
